keypad_scan_debounce: RTL and testbench

- Drives the 4x4 matrix keypad rows and samples its columns.
- Debounces all 16 keys on whole-frame snapshots.
- Emits a one-cycle key-press event with a 4-bit key code, plus a held-key level and the full debounced key map.
- Sits directly upstream of the number-entry/display path.
- Replaces ad-hoc row rotation and per-row decoding with a clean event interface.

---
 rtl/keypad_scan_debounce_pkg.sv | 20 ++
 rtl/keypad_scan_debounce_row_scanner.sv | 67 ++++++
 rtl/keypad_scan_debounce.sv | 93 +++++++++
 tb/tb_keypad_scan_debounce.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_debounce_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and debouncer.
package keypad_scan_debounce_pkg;

  localparam logic [3:0] ROW_INIT  = 4'b0111;
  localparam int         KEY_COUNT = 16;

  // {row[1:0], col[1:0]}
  typedef logic [3:0] key_code_t;

  // Lowest set index wins when several keys become pressed in one commit.
  function automatic key_code_t lowest_key(input logic [KEY_COUNT-1:0] keys);
    key_code_t code;
    code = '0;
    for (int i = KEY_COUNT - 1; i >= 0; i--) begin
      if (keys[i]) code = key_code_t'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_row_scanner.sv
// Row rotation, column synchroniser and whole-frame snapshot assembly.
module keypad_row_scanner
  import keypad_scan_debounce_pkg::*;
#(
  parameter int SCAN_DIV = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           col,
  output logic [3:0]           row,
  output logic [KEY_COUNT-1:0] raw_frame,
  output logic                 frame_done
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           r_q, r_d;
  logic [3:0]           row_q, row_d;
  logic [3:0]           sync1_q, sync2_q;
  logic [KEY_COUNT-1:0] raw_q, raw_d;
  logic                 done_q, done_d;
  logic                 dwell_end;

  assign dwell_end = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    r_d    = r_q;
    row_d  = row_q;
    raw_d  = raw_q;
    done_d = 1'b0;
    if (dwell_end) begin
      cnt_d = '0;
      // Column index c sits on col[3-c]; active-low pins become active-high keys.
      raw_d[{r_q, 2'b00} +: 4] = ~{sync2_q[0], sync2_q[1], sync2_q[2], sync2_q[3]};
      row_d  = {row_q[0], row_q[3:1]};
      r_d    = r_q + 2'd1;
      done_d = (r_q == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      r_q     <= '0;
      row_q   <= ROW_INIT;
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      raw_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      row_q   <= row_d;
      sync1_q <= col;
      sync2_q <= sync1_q;
      raw_q   <= raw_d;
      done_q  <= done_d;
    end
  end

  assign row        = row_q;
  assign raw_frame  = raw_q;
  assign frame_done = done_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner with frame-level debounce and one-cycle key-press events.
module keypad_scan_debounce
  import keypad_scan_debounce_pkg::*;
#(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           col,
  output logic [3:0]           row,
  output logic [KEY_COUNT-1:0] key_state,
  output key_code_t            key_code,
  output logic                 key_valid,
  output logic                 key_down
);

  localparam int             SW         = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0]  STABLE_MAX = SW'(DEBOUNCE_FRAMES);

  logic [KEY_COUNT-1:0] raw_frame;
  logic                 frame_done;

  logic [SW-1:0]        stable_q, stable_d;
  logic [KEY_COUNT-1:0] prev_q, prev_d;
  logic [KEY_COUNT-1:0] state_q, state_d;
  key_code_t            code_q, code_d;
  logic                 valid_q, valid_d;
  logic                 down_q, down_d;
  logic [KEY_COUNT-1:0] new_keys;

  keypad_row_scanner #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .raw_frame (raw_frame),
    .frame_done(frame_done)
  );

  always_comb begin
    stable_d = stable_q;
    prev_d   = prev_q;
    state_d  = state_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    new_keys = '0;
    if (frame_done) begin
      if (raw_frame == prev_q) begin
        stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
      end else begin
        stable_d = '0;
      end
      prev_d = raw_frame;
      // Releases commit silently; only newly pressed keys raise an event.
      if (stable_d == STABLE_MAX && raw_frame != state_q) begin
        state_d  = raw_frame;
        new_keys = raw_frame & ~state_q;
        if (new_keys != '0) begin
          valid_d = 1'b1;
          code_d  = lowest_key(new_keys);
        end
      end
    end
    down_d = |state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      prev_q   <= '0;
      state_q  <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      down_q   <= down_d;
    end
  end

  assign key_state = state_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench: ideal keypad matrix model plus a key-set level reference model.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_FRAMES = 2;
  localparam int LAT_MAX         = 2 + 4 * SCAN_DIV * (DEBOUNCE_FRAMES + 2) + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_state;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  logic [15:0] pressed     = 16'h0000;
  logic        bounce_open = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_total = 0;
  logic [3:0]  pulse_code  = 4'h0;
  logic [15:0] pulse_state = 16'h0;

  // Reference model: debounced key set and last reported code.
  logic [15:0] model_state = 16'h0;
  logic [3:0]  model_code  = 4'h0;

  keypad_scan_debounce #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .key_state(key_state),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal matrix: a pressed key (r,c) pulls col[3-c] low while row[3-r] is low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[3-r] && pressed[r*4+c] && !bounce_open) col[3-c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulse_total = pulse_total + 1;
      pulse_code  = key_code;
      pulse_state = key_state;
    end
  end

  function automatic logic [3:0] ref_lowest(input logic [15:0] k);
    for (int i = 0; i < 16; i++) if (k[i]) return 4'(i);
    return 4'h0;
  endfunction

  // Waits (bounded) for key_state to reach target, then watches a while longer.
  task automatic settle(input logic [15:0] target, output int pulses, output logic [3:0] code,
                        output logic [15:0] pstate, output int latency, output bit timeout);
    int base, start;
    bit reached;
    base = pulse_total; start = cyc; reached = 0; latency = -1;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      if (key_state === target) begin reached = 1; latency = cyc - start; end
    end
    repeat (48) @(negedge clk);
    timeout = !reached;
    pulses  = pulse_total - base;
    code    = pulse_code;
    pstate  = pulse_state;
  endtask

  task automatic drive_keys(input logic [15:0] k);
    @(posedge clk); #1;
    pressed = k;
  endtask

  task automatic test_reset();
    int base;
    @(negedge clk);
    checks++; if (row !== 4'b0111) begin errors++; $display("FAIL reset_row: got %b expected 0111", row); end
    checks++; if ({key_state, key_code, key_valid, key_down} !== 22'h0) begin errors++;
      $display("FAIL reset_outputs: got state=%h code=%h valid=%b down=%b expected all 0", key_state, key_code, key_valid, key_down); end
    rst = 1'b0;
    base = pulse_total;
    repeat (3) @(posedge clk); #1;
    checks++; if (row !== 4'b0111) begin errors++; $display("FAIL row_clk3: got %b expected 0111", row); end
    @(posedge clk); #1;
    checks++; if (row !== 4'b1011) begin errors++; $display("FAIL row_clk4: got %b expected 1011", row); end
    repeat (11) @(posedge clk); #1;
    checks++; if (row !== 4'b1110) begin errors++; $display("FAIL row_clk15: got %b expected 1110", row); end
    @(posedge clk); #1;
    checks++; if (row !== 4'b0111) begin errors++; $display("FAIL row_clk16: got %b expected 0111", row); end
    repeat (48) @(negedge clk);
    checks++; if (pulse_total - base !== 0 || key_state !== 16'h0) begin errors++;
      $display("FAIL idle_no_keys: got pulses=%0d state=%h expected 0 and 0000", pulse_total - base, key_state); end
  endtask

  task automatic test_single_press();
    int p, lat; logic [3:0] c; logic [15:0] s; bit to;
    drive_keys(16'h0040);
    settle(16'h0040, p, c, s, lat, to);
    checks++; if (to || lat > LAT_MAX) begin errors++; $display("FAIL press_latency: got %0d (timeout=%0b) expected <= %0d", lat, to, LAT_MAX); end
    checks++; if (p !== 1) begin errors++; $display("FAIL press_pulses: got %0d expected 1", p); end
    checks++; if (c !== 4'h6 || s !== 16'h0040) begin errors++; $display("FAIL press_event: got code=%h state=%h expected 6/0040", c, s); end
    checks++; if (key_down !== 1'b1 || key_code !== 4'h6) begin errors++; $display("FAIL press_held: got down=%b code=%h expected 1/6", key_down, key_code); end
    model_state = 16'h0040; model_code = 4'h6;
  endtask

  task automatic test_release();
    int p, lat; logic [3:0] c; logic [15:0] s; bit to;
    drive_keys(16'h0000);
    settle(16'h0000, p, c, s, lat, to);
    checks++; if (to || lat > LAT_MAX) begin errors++; $display("FAIL release_latency: got %0d (timeout=%0b) expected <= %0d", lat, to, LAT_MAX); end
    checks++; if (p !== 0) begin errors++; $display("FAIL release_pulses: got %0d expected 0", p); end
    checks++; if (key_down !== 1'b0 || key_code !== model_code) begin errors++;
      $display("FAIL release_hold_code: got down=%b code=%h expected 0/%h", key_down, key_code, model_code); end
    model_state = 16'h0000;
  endtask

  task automatic test_bounce();
    int base, p, lat; logic [3:0] c; logic [15:0] s; bit to, early;
    base = pulse_total; early = 0;
    drive_keys(16'h0040);
    for (int t = 0; t < 16; t++) begin
      repeat (5) begin @(negedge clk); if (key_state !== 16'h0) early = 1; end
      bounce_open = ~bounce_open;
    end
    bounce_open = 1'b0;
    checks++; if (early || pulse_total - base !== 0) begin errors++;
      $display("FAIL bounce_no_commit: got early=%0b pulses=%0d expected 0/0", early, pulse_total - base); end
    settle(16'h0040, p, c, s, lat, to);
    checks++; if (to || p !== 1 || c !== 4'h6) begin errors++;
      $display("FAIL bounce_settle: got pulses=%0d code=%h timeout=%0b expected 1/6/0", p, c, to); end
    model_state = 16'h0040; model_code = 4'h6;
  endtask

  task automatic test_simultaneous();
    int p, lat; logic [3:0] c; logic [15:0] s; bit to;
    drive_keys(16'h0208);
    settle(16'h0208, p, c, s, lat, to);
    checks++; if (to || p !== 1 || c !== 4'h3 || s !== 16'h0208) begin errors++;
      $display("FAIL simul_pair: got pulses=%0d code=%h state=%h expected 1/3/0208", p, c, s); end
    drive_keys(16'h0209);
    settle(16'h0209, p, c, s, lat, to);
    checks++; if (to || p !== 1 || c !== 4'h0 || s !== 16'h0209) begin errors++;
      $display("FAIL simul_add: got pulses=%0d code=%h state=%h expected 1/0/0209", p, c, s); end
    model_state = 16'h0209; model_code = 4'h0;
  endtask

  task automatic test_reset_mid();
    int p, lat; logic [3:0] c; logic [15:0] s; bit to;
    drive_keys(16'h0020);
    settle(16'h0020, p, c, s, lat, to);
    checks++; if (to || p !== 1 || c !== 4'h5) begin errors++;
      $display("FAIL pre_reset_press: got pulses=%0d code=%h expected 1/5", p, c); end
    repeat ($urandom_range(1, 15)) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (row !== 4'b0111 || {key_state, key_code, key_valid, key_down} !== 22'h0) begin errors++;
      $display("FAIL mid_reset: got row=%b state=%h code=%h valid=%b down=%b expected 0111 and 0", row, key_state, key_code, key_valid, key_down); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_state = 16'h0; model_code = 4'h0;
    settle(16'h0020, p, c, s, lat, to);
    checks++; if (to || p !== 1 || c !== 4'h5 || s !== 16'h0020) begin errors++;
      $display("FAIL post_reset_rereport: got pulses=%0d code=%h state=%h expected 1/5/0020", p, c, s); end
    model_state = 16'h0020; model_code = 4'h5;
  endtask

  task automatic test_random();
    int p, lat; logic [3:0] c; logic [15:0] s; bit to;
    logic [15:0] target, fresh;
    bit exp_pulse;
    for (int it = 0; it < 10; it++) begin
      target = 16'h0;
      repeat ($urandom_range(0, 3)) target[$urandom_range(0, 15)] = 1'b1;
      fresh     = target & ~model_state;
      exp_pulse = (fresh != 16'h0);
      repeat ($urandom_range(0, 15)) @(posedge clk);
      drive_keys(target);
      settle(target, p, c, s, lat, to);
      if (exp_pulse) model_code = ref_lowest(fresh);
      model_state = target;
      checks++; if (to || lat > LAT_MAX) begin errors++;
        $display("FAIL rand%0d_latency: got %0d (timeout=%0b) expected <= %0d", it, lat, to, LAT_MAX); end
      checks++; if (p !== (exp_pulse ? 1 : 0)) begin errors++;
        $display("FAIL rand%0d_pulses: got %0d expected %0d", it, p, exp_pulse ? 1 : 0); end
      checks++; if (key_code !== model_code || key_down !== (target != 16'h0)) begin errors++;
        $display("FAIL rand%0d_outputs: got code=%h down=%b expected %h/%b", it, key_code, key_down, model_code, target != 16'h0); end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_release();
    test_simultaneous();
    test_release();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
